// File: rtl/xc_aesmix_pkg.sv
// Shared types and GF(2^8) helpers for the multi-column AES mix unit.
// Coefficients cover both MixColumns and InvMixColumns (XC_AESMIX_MULTI_DEC_EN selects use).
package xc_aesmix_pkg;

  localparam int COL_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] FWD_COEF [4] = '{4'h2, 4'h3, 4'h1, 4'h1};
  localparam logic [3:0] INV_COEF [4] = '{4'he, 4'hb, 4'hd, 4'h9};

  function automatic logic [7:0] xt2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficients are constants at every call site, so the unused terms fold away.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] a2;
    logic [7:0] a4;
    logic [7:0] a8;
    a2 = xt2(a);
    a4 = xt2(a2);
    a8 = xt2(a4);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & a2) ^ ({8{c[2]}} & a4) ^ ({8{c[3]}} & a8);
  endfunction

endpackage

// File: rtl/xc_aesmix_col.sv
// Combinational single-column MixColumns transform.
// Inverse path is built only when XC_AESMIX_MULTI_DEC_EN is defined.
module xc_aesmix_col
  import xc_aesmix_pkg::*;
(
  input  logic [COL_W-1:0] col,
  input  logic             enc,
  output logic [COL_W-1:0] mixed
);

  logic [7:0] b [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      logic [7:0] fwd;
      assign b[gi] = col[8*gi +: 8];
      // Row gi is the base coefficient row rotated right by gi.
      assign fwd = gf_mul(b[gi], FWD_COEF[0]) ^ gf_mul(b[(gi+1)%4], FWD_COEF[1]) ^
                   gf_mul(b[(gi+2)%4], FWD_COEF[2]) ^ gf_mul(b[(gi+3)%4], FWD_COEF[3]);
`ifdef XC_AESMIX_MULTI_DEC_EN
      logic [7:0] inv;
      assign inv = gf_mul(b[gi], INV_COEF[0]) ^ gf_mul(b[(gi+1)%4], INV_COEF[1]) ^
                   gf_mul(b[(gi+2)%4], INV_COEF[2]) ^ gf_mul(b[(gi+3)%4], INV_COEF[3]);
      assign mixed[8*gi +: 8] = enc ? fwd : inv;
`else
      assign mixed[8*gi +: 8] = fwd;
`endif
    end
  endgenerate

`ifndef XC_AESMIX_MULTI_DEC_EN
  logic unused_enc;
  assign unused_enc = enc;
`endif

endmodule

// File: rtl/xc_aesmix_multi.sv
// Multi-column AES MixColumns unit: LANES columns per cycle over COLS columns.
// Define XC_AESMIX_MULTI_DEC_EN to enable InvMixColumns (enc = 0).
module xc_aesmix_multi
  import xc_aesmix_pkg::*;
#(
  parameter int COLS  = 4,
  parameter int LANES = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [COL_W-1:0]      flush_data,
  input  logic                  valid,
  input  logic                  enc,
  input  logic [COL_W*COLS-1:0] data,
  output logic                  ready,
  output logic [COL_W*COLS-1:0] result
);

  localparam int K  = COLS / LANES;
  localparam int GW = (K > 1) ? $clog2(K) : 1;

  generate
    if (!(COLS == 1 || COLS == 2 || COLS == 4) || (COLS % LANES) != 0) begin : g_bad_cfg
      $error("xc_aesmix_multi: COLS must be 1, 2 or 4 and divisible by LANES");
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [GW-1:0]   grp_reg, grp_next, grp_sel;
  logic            write_en;
  logic [COL_W-1:0] lane_in  [LANES];
  logic [COL_W-1:0] lane_out [LANES];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      grp_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grp_reg   <= grp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grp_next   = grp_reg;
    write_en   = 1'b0;
    if (flush) begin
      state_next = IDLE;
      grp_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid) begin
            write_en   = 1'b1;
            grp_next   = GW'(1);
            state_next = (K == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (!valid) begin
            state_next = IDLE;
            grp_next   = '0;
          end else begin
            write_en = 1'b1;
            grp_next = grp_reg + GW'(1);
            if (grp_reg == GW'(K - 1)) state_next = DONE;
          end
        end
        DONE: begin
          state_next = IDLE;
          grp_next   = '0;
        end
        default: begin
          state_next = IDLE;
          grp_next   = '0;
        end
      endcase
    end
  end

  // IDLE always works on group 0; only BUSY walks the counter.
  assign grp_sel = (K > 1 && state_reg == BUSY) ? grp_reg : '0;
  assign ready   = (state_reg == DONE);

  genvar gi, gj;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (K == 1) begin : g_direct
        assign lane_in[gi] = data[COL_W*gi +: COL_W];
      end else begin : g_mux
        logic [COL_W-1:0] grp_col [K];
        for (gj = 0; gj < K; gj++) begin : g_grp
          assign grp_col[gj] = data[COL_W*(gj*LANES + gi) +: COL_W];
        end
        assign lane_in[gi] = grp_col[grp_sel];
      end

      xc_aesmix_col u_col (
        .col   (lane_in[gi]),
        .enc   (enc),
        .mixed (lane_out[gi])
      );
    end

    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic             col_we;
      logic [COL_W-1:0] col_reg;
      assign col_we = write_en && (grp_sel == GW'(gi / LANES));

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     col_reg <= '0;
        else if (flush)  col_reg <= flush_data;
        else if (col_we) col_reg <= lane_out[gi % LANES];
      end

      assign result[COL_W*gi +: COL_W] = col_reg;
    end
  endgenerate

endmodule

// File: tb/tb_xc_aesmix_multi.sv
// Directed bench for xc_aesmix_multi: COLS=1, COLS=4/LANES=1 and COLS=4/LANES=4 instances.
// Expected inverse results depend on XC_AESMIX_MULTI_DEC_EN.
module tb_xc_aesmix_multi;

  logic         clock = 1'b0;
  logic         resetn = 1'b1;
  logic         flush = 1'b0;
  logic [31:0]  flush_data = '0;
  logic         enc = 1'b1;
  logic         v1 = 1'b0, v4 = 1'b0, vf = 1'b0;
  logic [31:0]  d1 = '0;
  logic [127:0] d4 = '0;
  logic         r1, r4, rf;
  logic [31:0]  q1;
  logic [127:0] q4, qf;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] VA = {32'h01010101, 32'hc6c6c6c6, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] XA = {32'h01010101, 32'hc6c6c6c6, 32'h9d58dc9f, 32'hbca14d8e};
  localparam logic [127:0] VB = {32'h455313db, 32'h5c220af2, 32'hc6c6c6c6, 32'h01010101};
  localparam logic [127:0] XB = {32'hbca14d8e, 32'h9d58dc9f, 32'hc6c6c6c6, 32'h01010101};
  localparam logic [127:0] AB = {32'h455313db, 32'h455313db, 32'h455313db, 32'h5c220af2};

  always #5 clock = ~clock;

  xc_aesmix_multi #(.COLS(1), .LANES(1)) u_c1 (
    .clock(clock), .resetn(resetn), .flush(flush), .flush_data(flush_data),
    .valid(v1), .enc(enc), .data(d1), .ready(r1), .result(q1));

  xc_aesmix_multi #(.COLS(4), .LANES(1)) u_c4 (
    .clock(clock), .resetn(resetn), .flush(flush), .flush_data(flush_data),
    .valid(v4), .enc(enc), .data(d4), .ready(r4), .result(q4));

  xc_aesmix_multi #(.COLS(4), .LANES(4)) u_f4 (
    .clock(clock), .resetn(resetn), .flush(flush), .flush_data(flush_data),
    .valid(vf), .enc(enc), .data(d4), .ready(rf), .result(qf));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the ready pulse.
  task automatic run_op(input int which, input logic e, input logic [127:0] d,
                        input logic [127:0] exp, input int lat, input string tag);
    int           cnt;
    logic         rdy;
    logic [127:0] got;
    enc = e;
    case (which)
      0:       begin d1 = d[31:0]; v1 = 1'b1; end
      1:       begin d4 = d; v4 = 1'b1; end
      default: begin d4 = d; vf = 1'b1; end
    endcase
    cnt = 0;
    rdy = 1'b0;
    while (!rdy && cnt < 20) begin
      @(posedge clock); #1;
      cnt++;
      rdy = (which == 0) ? r1 : (which == 1) ? r4 : rf;
    end
    v1 = 1'b0; v4 = 1'b0; vf = 1'b0;
    got = (which == 0) ? {96'b0, q1} : (which == 1) ? q4 : qf;
    check({tag, "_lat"}, cnt, lat);
    check(tag, got, exp);
    $display("txn %s lat=%0d result=%h", tag, cnt, got);
    @(posedge clock); #1;
    rdy = (which == 0) ? r1 : (which == 1) ? r4 : rf;
    check({tag, "_pulse"}, rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // Reset
    #1 resetn = 1'b0;
    #1;
    check("rst_ready", {r1, r4, rf}, 3'b000);
    check("rst_q4", q4, 128'h0);
    check("rst_q1", q1, 32'h0);
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Single-column forward / inverse
    run_op(0, 1'b1, 128'h455313db, 128'hbca14d8e, 1, "c1_fwd");
`ifdef XC_AESMIX_MULTI_DEC_EN
    run_op(0, 1'b0, 128'hbca14d8e, 128'h455313db, 1, "c1_inv");
`else
    run_op(0, 1'b0, 128'hbca14d8e, 128'h064550cd, 1, "c1_inv");
`endif

    // Four columns, one lane
    run_op(1, 1'b1, VA, XA, 4, "c4_fwd");

    // Abort after two cycles in flight
    enc = 1'b1; d4 = AB; v4 = 1'b1;
    seen = 1'b0;
    @(posedge clock); #1; seen |= r4;
    @(posedge clock); #1; seen |= r4;
    v4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1; seen |= r4;
    end
    check("abort_noready", seen, 1'b0);
    check("abort_partial", q4, {32'h01010101, 32'hc6c6c6c6, 32'hbca14d8e, 32'h9d58dc9f});
    $display("txn abort result=%h", q4);
    run_op(1, 1'b1, VB, XB, 4, "c4_after_abort");

    // Four columns, four lanes
    run_op(2, 1'b1, VA, XA, 1, "f4_fwd");
`ifdef XC_AESMIX_MULTI_DEC_EN
    run_op(2, 1'b0, XA, VA, 1, "f4_inv");
`else
    run_op(2, 1'b0, VB, XB, 1, "f4_inv");
`endif

    // Flush mid-BUSY
    enc = 1'b1; d4 = VA; v4 = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    flush = 1'b1; flush_data = 32'hdeadbeef; v4 = 1'b0;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_ready", r4, 1'b0);
    check("flush_q4", q4, {4{32'hdeadbeef}});
    check("flush_q1", q1, 32'hdeadbeef);
    $display("txn flush result=%h", q4);
    @(posedge clock); #1;
    check("flush_idle", r4, 1'b0);

    // Flush and valid together: flush wins
    enc = 1'b1; d1 = 32'h455313db; v1 = 1'b1; flush = 1'b1; flush_data = 32'h12345678;
    @(posedge clock); #1;
    flush = 1'b0; v1 = 1'b0;
    seen = r1;
    @(posedge clock); #1; seen |= r1;
    @(posedge clock); #1; seen |= r1;
    check("flush_wins_ready", seen, 1'b0);
    check("flush_wins_q1", q1, 32'h12345678);
    $display("txn flush_valid result=%h", q1);

    // Asynchronous reset mid-BUSY
    enc = 1'b1; d4 = VA; v4 = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #2;
    resetn = 1'b0;
    #1;
    check("arst_ready", r4, 1'b0);
    check("arst_q4", q4, 128'h0);
    check("arst_q1", q1, 32'h0);
    v4 = 1'b0;
    @(negedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    $display("txn async_reset result=%h", q4);

    // Back-to-back after release
    run_op(1, 1'b1, VA, XA, 4, "b2b_0");
    run_op(1, 1'b1, VB, XB, 4, "b2b_1");
    run_op(0, 1'b1, 128'h5c220af2, 128'h9d58dc9f, 1, "b2b_c1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
